// File: rtl/cpu_pkg.sv
// Shared constants for the CPU user-memory space: I/O base, register offsets,
// CTRL/STATUS bit positions and the address decode helper.
package cpu_pkg;

   localparam logic [7:0] IO_BASE_DEFAULT = 8'hF0;

   localparam logic [7:0] OFF_GPIO_OUT = 8'd0;
   localparam logic [7:0] OFF_GPIO_IN  = 8'd1;
   localparam logic [7:0] OFF_RELOAD   = 8'd2;
   localparam logic [7:0] OFF_COUNT    = 8'd3;
   localparam logic [7:0] OFF_CTRL     = 8'd4;
   localparam logic [7:0] OFF_STATUS   = 8'd5;

   localparam int CTRL_TEN = 0;
   localparam int CTRL_TIE = 1;
   localparam int CTRL_GIE = 2;
   localparam int STAT_TF  = 0;
   localparam int STAT_GF  = 1;

   typedef struct packed {
      logic gie;
      logic tie;
      logic ten;
   } ctrl_t;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_GPIO_OUT,
      SEL_GPIO_IN,
      SEL_RELOAD,
      SEL_COUNT,
      SEL_CTRL,
      SEL_STATUS,
      SEL_NONE
   } reg_sel_e;

   function automatic reg_sel_e decode_addr(input logic [7:0] addr, input logic [7:0] base);
      reg_sel_e   sel;
      logic [7:0] off;
      off = addr - base;
      sel = SEL_NONE;
      if (addr < base) begin
         sel = SEL_RAM;
      end else begin
         case (off)
            OFF_GPIO_OUT: sel = SEL_GPIO_OUT;
            OFF_GPIO_IN:  sel = SEL_GPIO_IN;
            OFF_RELOAD:   sel = SEL_RELOAD;
            OFF_COUNT:    sel = SEL_COUNT;
            OFF_CTRL:     sel = SEL_CTRL;
            OFF_STATUS:   sel = SEL_STATUS;
            default:      sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

   // Sticky flags: a set request on the same edge as a clear always wins.
   function automatic logic [1:0] flags_next(input logic [1:0] cur, input logic [1:0] set,
                                             input logic [1:0] clr);
      return set | (cur & ~clr);
   endfunction

endpackage

// File: rtl/user_timer.sv
// Down-counting reload timer: COUNT decrements while enabled and reloads from
// RELOAD after reaching zero, raising a one-cycle TF set request on that edge.
import cpu_pkg::*;

module user_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       ten,
   input  logic       ten_load,
   input  logic [7:0] reload,
   output logic [7:0] count,
   output logic       tf_set
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: an enable write restarts the period, otherwise count down and wrap.
   always_comb begin
      count_d = count_q;
      tf_set  = 1'b0;
      if (ten_load) begin
         count_d = reload;
      end else if (ten) begin
         if (count_q == 8'd0) begin
            count_d = reload;
            tf_set  = 1'b1;
         end else begin
            count_d = count_q - 8'd1;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/user_io.sv
// CPU user-memory slave: RAM below IO_BASE, GPIO/timer/interrupt registers above,
// combinational reads and edge-committed writes.
import cpu_pkg::*;

module user_io #(
   parameter logic [7:0] IO_BASE = IO_BASE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] usermem_address,
   input  logic [7:0] usermem_data_out,
   input  logic       rw,
   output logic [7:0] usermem_data_in,
   output logic       interrupt,
   input  logic [7:0] gpio_in,
   output logic [7:0] gpio_out
);

   logic [7:0] ram_q [0:int'(IO_BASE)-1];

   logic [7:0] gpio_out_q, gpio_out_d;
   logic [7:0] reload_q,   reload_d;
   ctrl_t      ctrl_q,     ctrl_d;
   logic [1:0] status_q,   status_d;
   logic       irq_q,      irq_d;
   logic [7:0] sync1_q,    sync1_d;
   logic [7:0] sync2_q,    sync2_d;
   logic       sync3_q,    sync3_d;

   reg_sel_e   sel;
   logic       ten_load;
   logic       tf_set;
   logic       gf_set;
   logic [1:0] status_clr;
   logic [7:0] count;

   user_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .ten      (ctrl_q.ten),
      .ten_load (ten_load),
      .reload   (reload_q),
      .count    (count),
      .tf_set   (tf_set)
   );

   // Address decode and write-side strobes.
   always_comb begin
      sel        = decode_addr(usermem_address, IO_BASE);
      ten_load   = 1'b0;
      status_clr = 2'b00;
      if (rw && (sel == SEL_CTRL)) begin
         ten_load = usermem_data_out[CTRL_TEN] & ~ctrl_q.ten;
      end else begin
         ten_load = 1'b0;
      end
      if (rw && (sel == SEL_STATUS)) begin
         status_clr = usermem_data_out[1:0];
      end else begin
         status_clr = 2'b00;
      end
   end

   // Register next-state, synchroniser shift and interrupt request.
   always_comb begin
      gpio_out_d = gpio_out_q;
      reload_d   = reload_q;
      ctrl_d     = ctrl_q;
      if (rw) begin
         case (sel)
            SEL_GPIO_OUT: gpio_out_d = usermem_data_out;
            SEL_RELOAD:   reload_d   = usermem_data_out;
            SEL_CTRL:     ctrl_d     = ctrl_t'(usermem_data_out[2:0]);
            default:      gpio_out_d = gpio_out_q;
         endcase
      end else begin
         gpio_out_d = gpio_out_q;
      end
      // The third flop only needs bit 0: it remembers the previous synchronised level.
      gf_set   = sync2_q[0] & ~sync3_q;
      sync1_d  = gpio_in;
      sync2_d  = sync1_q;
      sync3_d  = sync2_q[0];
      status_d = flags_next(status_q, {gf_set, tf_set}, status_clr);
      irq_d    = (status_q[STAT_TF] & ctrl_q.tie) | (status_q[STAT_GF] & ctrl_q.gie);
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpio_out_q <= 8'd0;
         reload_q   <= 8'd0;
         ctrl_q     <= ctrl_t'(3'd0);
         status_q   <= 2'd0;
         irq_q      <= 1'b0;
         sync1_q    <= 8'd0;
         sync2_q    <= 8'd0;
         sync3_q    <= 1'b0;
      end else begin
         gpio_out_q <= gpio_out_d;
         reload_q   <= reload_d;
         ctrl_q     <= ctrl_d;
         status_q   <= status_d;
         irq_q      <= irq_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         sync3_q    <= sync3_d;
      end
   end

   // RAM keeps its contents through reset, but a write during reset is dropped.
   always_ff @(posedge clk) begin
      if (rw && reset && (sel == SEL_RAM)) begin
         ram_q[usermem_address] <= usermem_data_out;
      end
   end

   // Combinational read mux.
   always_comb begin
      usermem_data_in = 8'h00;
      case (sel)
         SEL_RAM:      usermem_data_in = ram_q[usermem_address];
         SEL_GPIO_OUT: usermem_data_in = gpio_out_q;
         SEL_GPIO_IN:  usermem_data_in = sync2_q;
         SEL_RELOAD:   usermem_data_in = reload_q;
         SEL_COUNT:    usermem_data_in = count;
         SEL_CTRL:     usermem_data_in = {5'd0, ctrl_q};
         SEL_STATUS:   usermem_data_in = {6'd0, status_q};
         default:      usermem_data_in = 8'h00;
      endcase
   end

   assign gpio_out  = gpio_out_q;
   assign interrupt = irq_q;

endmodule

// File: doc/user_io.md
USER_IO -- requirements
Module: user_io

Interface
REQ-001 Parameter IO_BASE, default 8'hF0; RAM occupies 0x00..IO_BASE-1, I/O registers occupy IO_BASE..IO_BASE+5.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 usermem_address  input  8  CPU user-memory address.
REQ-005 usermem_data_out  input  8  CPU write data.
REQ-006 rw  input  1  1 = write at the next rising edge, 0 = read.
REQ-007 usermem_data_in  output  8  read data returned to the CPU.
REQ-008 interrupt  output  1  level interrupt request to the CPU.
REQ-009 gpio_in  input  8  asynchronous external inputs.
REQ-010 gpio_out  output  8  registered external outputs.

Function
REQ-011 Reads SHALL be combinational: usermem_data_in reflects the addressed location in the same cycle, independent of rw.
REQ-012 Writes SHALL commit on the rising edge of clk when rw=1; a read of the same address in the following cycle SHALL return the new value.
REQ-013 RAM: IO_BASE bytes; reads and writes as above; contents not reset.
REQ-014 Register map, offsets from IO_BASE: +0 GPIO_OUT (R/W); +1 GPIO_IN (RO, synchronised value); +2 RELOAD (R/W); +3 COUNT (RO); +4 CTRL (R/W, bit0 TEN, bit1 TIE, bit2 GIE, bits 7:3 read 0); +5 STATUS (bit0 TF, bit1 GF, W1C, bits 7:2 read 0).
REQ-015 Addresses IO_BASE+6..0xFF SHALL read 8'h00; writes to them, and to RO registers, SHALL be ignored.
REQ-016 gpio_in SHALL pass through a 2-flop synchroniser; GPIO_IN returns the second flop.
REQ-017 GF SHALL set on a 0->1 transition of synchronised gpio_in[0], detected with a third flop; latency from the gpio_in edge to GF=1 is 3 clocks.
REQ-018 Timer: while TEN=1, COUNT decrements by 1 each clock; when COUNT=0, COUNT reloads from RELOAD on the next clock and TF sets on that edge; the period is RELOAD+1 clocks.
REQ-019 A write setting TEN 0->1 SHALL load COUNT from RELOAD on the same edge; while TEN=0, COUNT holds.
REQ-020 RELOAD=0 with TEN=1 SHALL set TF on every clock.
REQ-021 When a flag set event and a W1C clear of the same flag occur on the same edge, the set SHALL win.
REQ-022 A RELOAD write while TEN=1 SHALL NOT alter COUNT; the new value applies at the next reload.
REQ-023 interrupt SHALL be registered: interrupt <= (TF & TIE) | (GF & GIE); it asserts 1 clock after the enabling flag/enable condition and deasserts 1 clock after the condition clears.
REQ-024 gpio_out SHALL equal the GPIO_OUT register.

Reset
REQ-025 While reset=0: GPIO_OUT, RELOAD, COUNT, CTRL, STATUS, synchroniser and edge flops, and interrupt SHALL be 0, asynchronously.
REQ-026 A write coincident with reset assertion SHALL be lost; RAM contents are undefined after power-up and preserved across reset.
REQ-027 Timer counting and edge detection SHALL start on the first rising edge after reset deasserts, and no GF SHALL set from pre-reset input history.

Structure
REQ-028 Register offsets, CTRL/STATUS bit positions and the IO_BASE default SHALL live in a shared package, cpu_pkg, reused by software tests and the CPU top level.
REQ-029 The timer (COUNT, RELOAD compare, TF set request) SHALL be one sub-module, user_timer; RAM, decode, GPIO and interrupt logic stay in user_io.
REQ-030 user_io SHALL connect to cpu through its usermem_*, rw and interrupt ports with no glue logic.

Verification
REQ-031 Write 0x5A to 0x10, then read 0x10 on the next cycle -> 0x5A; read 0xF8 -> 0x00; write 0xF8, then read 0xF8 -> 0x00.
REQ-032 RELOAD=3, CTRL=0x03 -> TF sets every 4 clocks; interrupt rises 1 clock after TF; write 0x01 to STATUS -> interrupt falls 1 clock later.
REQ-033 gpio_in[0] rising with GIE=1 -> GF=1 after 3 clocks and interrupt=1 after 4 clocks; gpio_in[0] held high -> no further GF.
REQ-034 RELOAD=0, TEN=1; W1C of TF on the same edge as a timer expiry -> TF reads 1.
REQ-035 Assert reset mid-count with GPIO_OUT=0xFF -> gpio_out=0x00, COUNT=0 and interrupt=0 immediately, without a clock edge; RAM byte written before reset is unchanged.
